// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one register-file instruction at a time, drives an external ALU, writes back and returns the result.
module alu_sequencer #(
    parameter int WIDTH = 4,
    parameter int OPW   = 3,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_ld,
    input  logic [OPW-1:0]   cmd_op,
    input  logic [AW-1:0]    cmd_rd,
    input  logic [AW-1:0]    cmd_rs1,
    input  logic [AW-1:0]    cmd_rs2,
    input  logic             cmd_imm_en,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic [WIDTH-1:0] r_regs [2**AW];
    logic [AW-1:0]    r_rd;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [OPW-1:0]   r_alu_op;
    logic [WIDTH-1:0] r_rsp_data;

    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_op   = r_alu_op;
    assign rsp_data = r_rsp_data;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        cmd_ready = r_state == IDLE;
        rsp_valid = r_state == RESP;
        busy      = r_state != IDLE;
        w_accept  = cmd_valid && r_state == IDLE;
        case (r_state)
            IDLE:    if (w_accept) w_next = cmd_ld ? RESP : EXEC;
            EXEC:    w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operands are sampled at accept, so sources always see pre-write register values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**AW; i++) r_regs[i] <= '0;
            r_rd       <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_rsp_data <= '0;
        end else begin
            if (w_accept && cmd_ld) begin
                r_regs[cmd_rd] <= cmd_imm;
                r_rsp_data     <= cmd_imm;
            end
            if (w_accept && !cmd_ld) begin
                r_alu_a  <= r_regs[cmd_rs1];
                r_alu_b  <= cmd_imm_en ? cmd_imm : r_regs[cmd_rs2];
                r_alu_op <= cmd_op;
                r_rd     <= cmd_rd;
            end
            if (r_state == EXEC) begin
                r_regs[r_rd] <= alu_out;
                r_rsp_data   <= alu_out;
            end
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench with an ALU stub and a register-file reference model.
module tb_alu_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_ld = 1'b0;
    logic [2:0] cmd_op = '0;
    logic [1:0] cmd_rd = '0;
    logic [1:0] cmd_rs1 = '0;
    logic [1:0] cmd_rs2 = '0;
    logic       cmd_imm_en = 1'b0;
    logic [3:0] cmd_imm = '0;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       busy;

    typedef struct {
        logic [3:0] data;
        int         due;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] m_regs [4];
    logic [3:0] m_a = '0;
    logic [3:0] m_b = '0;
    logic [2:0] m_op = '0;
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         last_acc = 0;
    int         bp_mode = 0;
    bit         seen = 1'b0;
    logic [3:0] held = '0;

    alu_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ld(cmd_ld), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy)
    );

    function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        return op == 3'd0 ? 4'(a + b) : op == 3'd1 ? 4'(a - b) : a ^ b;
    endfunction

    assign alu_out = alu_f(alu_a, alu_b, alu_op);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_reset();
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_alu_a", 32'(alu_a), 0);
        chk("rst_alu_b", 32'(alu_b), 0);
        chk("rst_alu_op", 32'(alu_op), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        m_a = '0;
        m_b = '0;
        m_op = '0;
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic send(input bit ld, input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input bit ie, input logic [3:0] imm);
        int n = 0;
        exp_t e;
        logic [3:0] a, b;
        cmd_valid = 1'b1; cmd_ld = ld; cmd_op = op; cmd_rd = rd;
        cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm_en = ie; cmd_imm = imm;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(cmd_ready), 1);
        last_acc = cyc + 1;
        a = m_regs[rs1];
        b = ie ? imm : m_regs[rs2];
        e.data = ld ? imm : alu_f(a, b, op);
        e.due = last_acc + (ld ? 0 : 1);
        sb.push_back(e);
        m_regs[rd] = e.data;
        if (!ld) begin
            m_a = a;
            m_b = b;
            m_op = op;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("alu_a", 32'(alu_a), 32'(m_a));
        chk("alu_b", 32'(alu_b), 32'(m_b));
        chk("alu_op", 32'(alu_op), 32'(m_op));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = bp_mode == 0 ? 1'b1 : bp_mode == 1 ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin
        if (rst) seen = 1'b0;
        else begin
            chk("busy", 32'(busy), 32'(!cmd_ready));
            if (rsp_valid) begin
                chk("resp_cmd_ready", 32'(cmd_ready), 0);
                if (!seen) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL rsp_unexpected: got data %0d expected no response (cycle %0d)", rsp_data, cyc);
                    end else begin
                        chk("rsp_data", 32'(rsp_data), 32'(sb[0].data));
                        chk("rsp_latency", cyc, sb[0].due);
                    end
                    held = rsp_data;
                    seen = 1'b1;
                end else chk("rsp_hold", 32'(rsp_data), 32'(held));
                if (rsp_ready) begin
                    if (sb.size() != 0) void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int prev, c;
        bit prev_ld;
        bit lds [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        clear_model();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset();
        send(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 1'b0, 4'd9);
        send(1'b0, 3'd0, 2'd2, 2'd1, 2'd0, 1'b1, 4'd8);
        send(1'b0, 3'd1, 2'd1, 2'd1, 2'd2, 1'b0, 4'd0);
        send(1'b0, 3'd0, 2'd3, 2'd1, 2'd1, 1'b0, 4'd0);
        prev = last_acc;
        prev_ld = 1'b0;
        foreach (lds[i]) begin
            send(lds[i], 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            chk("cadence", last_acc - prev, prev_ld ? 2 : 3);
            prev = last_acc;
            prev_ld = lds[i];
        end
        wait_drain();
        bp_mode = 1;
        repeat (2) @(negedge clk);
        send(1'b0, 3'd1, 2'd0, 2'd2, 2'd3, 1'b0, 4'd0);
        cmd_valid = 1'b1; cmd_ld = 1'b1; cmd_rd = 2'd0; cmd_imm = 4'd5;
        repeat (5) begin
            @(negedge clk);
            chk("bp_cmd_ready", 32'(cmd_ready), 0);
            chk("bp_rsp_valid", 32'(rsp_valid), 1);
        end
        bp_mode = 0;
        c = cyc;
        send(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 4'd5);
        chk("bp_accept", last_acc, c + 3);
        send(1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 1'b1, 4'd3);
        rst = 1'b1;
        sb.delete();
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset();
        send(1'b0, 3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 4'd0);
        bp_mode = 2;
        for (int i = 0; i < 150; i++) begin
            send(1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        bp_mode = 0;
        wait_drain();
        chk("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-driven controller that sequences the 4-bit `alu` datapath. It holds a small register file and accepts one instruction at a time over a valid/ready handshake. For each instruction it drives the ALU operands and opcode from registers or an immediate, writes the ALU result back, and returns the result over a second valid/ready channel. It sits between a host/test driver and one combinational `alu` instance, which is external to this block.

## Interface
- `WIDTH`, 4, data width; matches the `alu` `a`/`b`/`out` width.
- `OPW`, 3, ALU opcode width; matches `alu` `op`.
- `AW`, 2, register address width; the register file has 2^AW entries.

- `clk`  in  1  rising-edge clock; the block has a single clock.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_ld`  in  1  1 = load `cmd_imm` into `rd` (no ALU); 0 = ALU operation.
- `cmd_op`  in  OPW  ALU opcode, passed through unmodified.
- `cmd_rd`  in  AW  destination register.
- `cmd_rs1`  in  AW  source for `alu_a`.
- `cmd_rs2`  in  AW  source for `alu_b` when `cmd_imm_en`=0.
- `cmd_imm_en`  in  1  1 = `alu_b` takes `cmd_imm`.
- `cmd_imm`  in  WIDTH  immediate operand / load value.
- `alu_a`, `alu_b`  out  WIDTH  registered ALU operands.
- `alu_op`  out  OPW  registered ALU opcode.
- `alu_out`  in  WIDTH  combinational ALU result.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_data`  out  WIDTH  result (ALU output or loaded immediate).
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`&&`cmd_ready` the command is accepted at that edge.
  - ALU command: latch `alu_a`←reg[rs1]; `alu_b`←`cmd_imm_en`?`cmd_imm`:reg[rs2]; `alu_op`←`cmd_op`; latch `rd`; next state EXEC.
  - Load command: reg[rd]←`cmd_imm` and `rsp_data`←`cmd_imm` at the accept edge; `alu_a`/`alu_b`/`alu_op` unchanged; next state RESP.
- EXEC:
  - Lasts exactly one cycle; the ALU sees stable registered inputs for the whole cycle.
  - At the end-of-cycle edge: reg[rd]←`alu_out`, `rsp_data`←`alu_out`; next state RESP.
- RESP:
  - `rsp_valid`=1 and `cmd_ready`=0.
  - `rsp_data` is held stable until `rsp_valid`&&`rsp_ready`; then next state IDLE.
  - A new command is never accepted in the same cycle as the response handshake.
- Source reads take the register value before any write from the same instruction.
  - rs1 == rd or rs2 == rd reads the old value.
  - No hazards exist, since only one instruction is in flight.
- Arithmetic: none in this block. The ALU result is truncated/wrapped by the ALU to WIDTH bits and stored as-is.
- `alu_a`, `alu_b` and `alu_op` hold their last values outside EXEC; they never glitch to other values.

## Timing
- Reset values: state IDLE; all registers 0; `alu_a`=`alu_b`=0; `alu_op`=0; `rsp_data`=0; `rsp_valid`=0; `busy`=0; `cmd_ready`=1 in the first cycle after reset deasserts.
- ALU command latency:
  - Accept edge at cycle k; EXEC during k+1.
  - `rsp_valid` is first high in cycle k+2.
  - Earliest next accept is the cycle after the response handshake, giving a minimum of 3 cycles per ALU command.
- Load latency: accept at k, `rsp_valid` high in cycle k+1; minimum 2 cycles per load.
- Backpressure: if `rsp_ready` stays low, the block stays in RESP indefinitely with all outputs frozen.
- `rst` has priority in every state:
  - A command mid-EXEC is discarded and its register write does not occur.
  - A pending response is dropped.
  - The FSM returns to IDLE next cycle and the register file is cleared.
- `cmd_valid` while `cmd_ready`=0 is ignored; the driver must hold it, and the block does not queue it.

## Test plan
The bench ALU stub computes op 0 = a+b mod 16, op 1 = a−b mod 16.
- Reset then idle → `cmd_ready`=1, `busy`=0, `rsp_valid`=0, `alu_a`/`alu_b`/`alu_op`=0.
- Load r1←9, then ALU op0 rd=r2, rs1=r1, imm_en=1, imm=8 → first response 9 at k+1; second response 1 (wraparound) at k+2; r2 holds 1.
- ALU op1 rd=r1, rs1=r1, rs2=r2 with r1=9, r2=1 → `rsp_data`=8; then op0 rd=r3, rs1=r1, rs2=r1 → 0 (8+8 wraps); confirms read-before-write.
- Backpressure: hold `rsp_ready`=0 for 5 cycles with `cmd_valid` high → `rsp_valid` and `rsp_data` stable, `cmd_ready`=0, no second accept; release → handshake, then accept the next cycle.
- Assert `rst` during EXEC of op0 rd=r0 → no response; after reset, r0 reads back 0 (verified via op0 rs1=r0, imm=0 → 0).
- Back-to-back commands with `rsp_ready` tied high → accept cadence of exactly 3 cycles for ALU ops and 2 for loads.
